// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: debounced start/stop and lap/clear keys drive an IDLE/RUN/PAUSE FSM
// that gates the Timer, issues its clear pulse and owns the live-or-frozen display value.

module stopwatch_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          stable;
    logic          stable_d;
    logic          level;

    assign level = sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync     <= 2'b11;
            cnt      <= '0;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            press    <= 1'b0;
        end else begin
            sync     <= {sync[0], key_n};
            stable_d <= stable;
            // only the 1->0 transition of the accepted level is an event
            press    <= stable_d & ~stable;
            if (level == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= level;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_start_n,
    input  logic       key_lap_n,
    input  logic [5:0] sec,
    input  logic [3:0] tenth_sec,
    output logic       en,
    output logic       timer_clear,
    output logic [5:0] disp_sec,
    output logic [3:0] disp_tenth_sec,
    output logic       lap_active,
    output logic       running
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t     state, state_nxt;
    logic [1:0] press;
    logic       start_ev, lap_ev;
    logic       lap_nxt, clear_nxt;

    // index 0: start/stop, index 1: lap/clear
    stopwatch_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db[1:0] (
        .clk   (clk),
        .reset (reset),
        .key_n ({key_lap_n, key_start_n}),
        .press (press)
    );

    assign start_ev = press[0];
    assign lap_ev   = press[1] & ~press[0];

    always_comb begin
        state_nxt = state;
        lap_nxt   = lap_active;
        clear_nxt = 1'b0;
        case (state)
            IDLE:  if (start_ev) state_nxt = RUN;
            RUN: begin
                if (start_ev)    state_nxt = PAUSE;
                else if (lap_ev) lap_nxt   = ~lap_active;
            end
            PAUSE: begin
                if (start_ev) begin
                    state_nxt = RUN;
                end else if (lap_ev) begin
                    state_nxt = IDLE;
                    lap_nxt   = 1'b0;
                    clear_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            en             <= 1'b0;
            timer_clear    <= 1'b1;
            lap_active     <= 1'b0;
            disp_sec       <= '0;
            disp_tenth_sec <= '0;
        end else begin
            state       <= state_nxt;
            en          <= (state_nxt == RUN);
            timer_clear <= clear_nxt;
            lap_active  <= lap_nxt;
            // the setting edge still sees lap_active low, so it captures; the clearing edge holds
            if (!lap_active) begin
                disp_sec       <= sec;
                disp_tenth_sec <= tenth_sec;
            end
        end
    end

    assign running = en;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4; expectations queued then checked.

module tb_stopwatch_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       key_start_n, key_lap_n;
    logic [5:0] sec;
    logic [3:0] tenth_sec;
    logic       en, timer_clear, lap_active, running;
    logic [5:0] disp_sec;
    logic [3:0] disp_tenth_sec;

    int checks = 0;
    int failures = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .key_start_n    (key_start_n),
        .key_lap_n      (key_lap_n),
        .sec            (sec),
        .tenth_sec      (tenth_sec),
        .en             (en),
        .timer_clear    (timer_clear),
        .disp_sec       (disp_sec),
        .disp_tenth_sec (disp_tenth_sec),
        .lap_active     (lap_active),
        .running        (running)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0d", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
            end
        end
    endtask

    // expect then check in one call keeps the directed list readable
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
        expect_val(tag, e);
        check(obs);
    endtask

    initial begin
        reset = 1'b1; key_start_n = 1'b1; key_lap_n = 1'b1;
        sec = 6'd5; tenth_sec = 4'd3;
        step(3);
        chk("rst_en", en, 0);
        chk("rst_clear", timer_clear, 1);
        chk("rst_disp_sec", disp_sec, 0);
        chk("rst_disp_tenth", disp_tenth_sec, 0);
        chk("rst_lap", lap_active, 0);
        chk("rst_running", running, 0);
        reset = 1'b0;
        step(1);
        chk("post_rst_clear", timer_clear, 0);
        chk("post_rst_en", en, 0);
        chk("post_rst_disp_sec", disp_sec, 5);
        chk("post_rst_disp_tenth", disp_tenth_sec, 3);

        // bounce: low 3, high 1, four times
        for (int r = 0; r < 4; r++) begin
            key_start_n = 1'b0; step(3);
            key_start_n = 1'b1; step(1);
        end
        step(10);
        chk("bounce_en", en, 0);

        // start latency
        key_start_n = 1'b0;
        step(7);
        chk("start_e7_en", en, 0);
        step(1);
        chk("start_e8_en", en, 1);
        chk("start_running", running, 1);
        step(5);
        chk("start_hold_en", en, 1);
        key_start_n = 1'b1;
        step(8);
        chk("start_release_en", en, 1);

        // lap capture
        sec = 6'd11; tenth_sec = 4'd2;
        key_lap_n = 1'b0;
        step(7);
        chk("lap_e7_lap", lap_active, 0);
        sec = 6'd12; tenth_sec = 4'd7;
        step(1);
        chk("lap_set", lap_active, 1);
        chk("lap_cap_sec", disp_sec, 12);
        chk("lap_cap_tenth", disp_tenth_sec, 7);
        sec = 6'd13; tenth_sec = 4'd8;
        step(3);
        chk("lap_hold_sec", disp_sec, 12);
        chk("lap_hold_tenth", disp_tenth_sec, 7);
        key_lap_n = 1'b1;
        step(8);
        chk("lap_release_lap", lap_active, 1);
        key_lap_n = 1'b0;
        step(8);
        chk("lap2_clear", lap_active, 0);
        chk("lap2_hold_sec", disp_sec, 12);
        step(1);
        chk("lap2_live_sec", disp_sec, 13);
        chk("lap2_live_tenth", disp_tenth_sec, 8);
        key_lap_n = 1'b1;
        step(8);

        // freeze again, pause, then clear
        key_lap_n = 1'b0; step(8);
        chk("lap3_set", lap_active, 1);
        key_lap_n = 1'b1; step(8);
        key_start_n = 1'b0; step(8);
        chk("pause_en", en, 0);
        chk("pause_lap_kept", lap_active, 1);
        key_start_n = 1'b1; step(8);
        key_lap_n = 1'b0;
        step(7);
        chk("clear_e7", timer_clear, 0);
        step(1);
        chk("clear_pulse", timer_clear, 1);
        chk("clear_en", en, 0);
        chk("clear_lap", lap_active, 0);
        step(1);
        chk("clear_drop", timer_clear, 0);
        key_lap_n = 1'b1; step(8);

        // lap in IDLE does nothing
        key_lap_n = 1'b0; step(8);
        chk("idle_lap_lap", lap_active, 0);
        chk("idle_lap_clear", timer_clear, 0);
        chk("idle_lap_en", en, 0);
        key_lap_n = 1'b1; step(8);

        // simultaneous presses in RUN
        key_start_n = 1'b0; step(8);
        chk("sim_run_en", en, 1);
        key_start_n = 1'b1; step(8);
        key_start_n = 1'b0; key_lap_n = 1'b0;
        step(8);
        chk("sim_en", en, 0);
        chk("sim_lap", lap_active, 0);
        chk("sim_clear", timer_clear, 0);
        key_start_n = 1'b1; key_lap_n = 1'b1; step(8);

        // reset mid-debounce with key held
        key_start_n = 1'b0;
        step(4);
        reset = 1'b1;
        step(1);
        chk("mid_rst_en", en, 0);
        chk("mid_rst_clear", timer_clear, 1);
        chk("mid_rst_lap", lap_active, 0);
        reset = 1'b0;
        step(1);
        chk("mid_rst_clear_drop", timer_clear, 0);
        step(6);
        chk("mid_rst_e7_en", en, 0);
        step(1);
        chk("mid_rst_e8_en", en, 1);
        step(10);
        chk("mid_rst_hold_en", en, 1);
        key_start_n = 1'b1;
        step(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
